// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, default
// widths and port indices.
package mem_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_MAX_BURST  = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_OWN0 = 2'd1;
    localparam arb_state_t ST_OWN1 = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way chooser: one-hot grant from two requests, with ties
// resolved away from the most recently granted port.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Pick the single requester, or on a tie the port that did not win last.
    always_comb begin
        gnt_o = 2'b00;
        case ({req1_i, req0_i})
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == PORT1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port-per-direction memory.
// Build option MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties in IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST - 1);

    arb_state_t            state_q, state_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

    logic [1:0]            pick_s;
    logic [1:0]            gnt_s;
    logic                  tie_last_s;
    logic [CNT_W-1:0]      base_cnt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_last_s = PORT1;
`else
    assign tie_last_s = last_q;
`endif

    rr_pick2 u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (tie_last_s),
        .gnt_o  (pick_s)
    );

    // An owning port keeps the grant while it requests; otherwise arbitrate fresh.
    always_comb begin
        gnt_s = 2'b00;
        if (!reset_n) begin
            gnt_s = 2'b00;
        end else begin
            case (state_q)
                ST_OWN0: gnt_s = req0 ? 2'b01 : pick_s;
                ST_OWN1: gnt_s = req1 ? 2'b10 : pick_s;
                default: gnt_s = pick_s;
            endcase
        end
    end

    // A burst continues only when the owner itself is re-granted; a new winner starts from zero.
    always_comb begin
        base_cnt_s = '0;
        if ((state_q == ST_OWN0 && gnt_s[0]) || (state_q == ST_OWN1 && gnt_s[1])) begin
            base_cnt_s = cnt_q;
        end else begin
            base_cnt_s = '0;
        end
    end

    // Next FSM state, burst counter and last-granted pointer.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        if (gnt_s[0]) begin
            last_d = PORT0;
            if (lock0 && (base_cnt_s < BURST_LIMIT)) begin
                state_d = ST_OWN0;
                cnt_d   = base_cnt_s + CNT_W'(1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (gnt_s[1]) begin
            last_d = PORT1;
            if (lock1 && (base_cnt_s < BURST_LIMIT)) begin
                state_d = ST_OWN1;
                cnt_d   = base_cnt_s + CNT_W'(1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Memory-side steering; address and data hold their last values when idle.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr_s = hold_addr_q;
        mem_data   = hold_data_q;
        if (gnt_s[0]) begin
            mem_we     = we0;
            mem_addr_s = addr0;
            mem_data   = wdata0;
        end else if (gnt_s[1]) begin
            mem_we     = we1;
            mem_addr_s = addr1;
            mem_data   = wdata1;
        end else begin
            mem_we     = 1'b0;
            mem_addr_s = hold_addr_q;
            mem_data   = hold_data_q;
        end
    end

    assign hold_addr_d = mem_addr_s;
    assign hold_data_d = mem_data;
    assign rvalid0_d   = gnt_s[0] & ~we0;
    assign rvalid1_d   = gnt_s[1] & ~we1;

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT1;
            cnt_q       <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign gnt0           = gnt_s[0];
    assign gnt1           = gnt_s[1];
    assign rvalid0        = rvalid0_q;
    assign rvalid1        = rvalid1_q;
    // The memory already registers its output, so read data is passed through while valid.
    assign rdata          = (rvalid0_q | rvalid1_q) ? mem_q : '0;
    assign mem_read_addr  = mem_addr_s;
    assign mem_write_addr = mem_addr_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_data, mem_q;
    logic [9:0]  mem_read_addr, mem_write_addr;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_data(mem_data),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    // Memory model: unwritten words read as 16'hA000 | address.
    logic [15:0]   mem_arr [0:1023];
    logic [1023:0] mem_vld;
    always @(posedge clk) begin
        if (!reset_n) begin
            mem_vld <= '0;
        end else if (mem_we) begin
            mem_arr[mem_write_addr] <= mem_data;
            mem_vld[mem_write_addr] <= 1'b1;
        end
        mem_q <= (reset_n && mem_vld[mem_read_addr]) ? mem_arr[mem_read_addr]
                                                     : (16'hA000 | {6'd0, mem_read_addr});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 10'h001; wdata0 = 16'h1234;
        cyc(); cyc(); #1;
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid0: got %b expected 0", rvalid0); end
        checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid1: got %b expected 0", rvalid1); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_both_read();
        cyc(); req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 10'h005; addr1 = 10'h006; #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL both_c1_gnt: got %b%b expected gnt1,gnt0=01", gnt1, gnt0); end
        checks++; if (mem_read_addr !== 10'h005) begin errors++; $display("FAIL both_c1_addr: got %h expected 005", mem_read_addr); end
        cyc(); req0 = 1'b0; #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL both_c2_gnt: got %b%b expected gnt1,gnt0=10", gnt1, gnt0); end
        checks++; if (rvalid0 !== 1'b1 || rdata !== 16'hA005) begin errors++; $display("FAIL both_c2_rd0: got v=%b d=%h expected v=1 d=a005", rvalid0, rdata); end
        cyc(); req1 = 1'b0; #1;
        checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 16'hA006) begin errors++; $display("FAIL both_c3_rd1: got v1=%b v0=%b d=%h expected 1 0 a006", rvalid1, rvalid0, rdata); end
    endtask

    task automatic test_write_read();
        cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3FF; wdata0 = 16'hBEEF; #1;
        checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt_we: got g=%b we=%b expected 1 1", gnt0, mem_we); end
        checks++; if (mem_write_addr !== 10'h3FF || mem_data !== 16'hBEEF) begin errors++; $display("FAIL wr_bus: got a=%h d=%h expected 3ff beef", mem_write_addr, mem_data); end
        cyc(); req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3FF; #1;
        checks++; if (gnt1 !== 1'b1 || mem_we !== 1'b0 || mem_read_addr !== 10'h3FF) begin errors++; $display("FAIL rd_grant: got g=%b we=%b a=%h expected 1 0 3ff", gnt1, mem_we, mem_read_addr); end
        cyc(); req1 = 1'b0; #1;
        checks++; if (rvalid1 !== 1'b1 || rdata !== 16'hBEEF) begin errors++; $display("FAIL raw_data: got v=%b d=%h expected 1 beef", rvalid1, rdata); end
    endtask

    task automatic test_burst();
        logic exp1;
        cyc(); req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 10'h010; req0 = 1'b0; #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL burst_c0: got %b%b expected 10", gnt1, gnt0); end
        for (int i = 1; i <= 8; i++) begin
            cyc(); req0 = 1'b1; we0 = 1'b0; addr0 = 10'h020; #1;
            exp1 = (i <= 7);
            checks++;
            if (gnt1 !== exp1 || gnt0 !== !exp1) begin
                errors++; $display("FAIL burst_c%0d: got gnt1,gnt0=%b%b expected %b%b", i, gnt1, gnt0, exp1, !exp1);
            end
        end
        cyc(); req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp0, prev0, prev1;
        int n0, n1;
        n0 = 0; n1 = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 1);
`endif
            checks++;
            if (gnt0 !== exp0 || gnt1 !== !exp0) begin
                errors++; $display("FAIL rr_c%0d: got gnt1,gnt0=%b%b expected %b%b", i, gnt1, gnt0, !exp0, exp0);
            end
            if (i > 0) begin
                checks++;
                if (rvalid0 !== prev0 || rvalid1 !== prev1) begin
                    errors++; $display("FAIL rr_rvalid_c%0d: got %b%b expected %b%b", i, rvalid1, rvalid0, prev1, prev0);
                end
            end
            n0 += (gnt0 === 1'b1) ? 1 : 0;
            n1 += (gnt1 === 1'b1) ? 1 : 0;
            prev0 = exp0; prev1 = !exp0;
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        checks++; if (n0 != 10 || n1 != 0) begin errors++; $display("FAIL rr_counts: got %0d/%0d expected 10/0", n0, n1); end
`else
        checks++; if (n0 != 5 || n1 != 5) begin errors++; $display("FAIL rr_counts: got %0d/%0d expected 5/5", n0, n1); end
`endif
        cyc(); req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_midburst();
        cyc(); req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 10'h030; #1;
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL mid_c0: got gnt1=%b expected 1", gnt1); end
        cyc(); req0 = 1'b1; we0 = 1'b0; addr0 = 10'h040; #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL mid_own1: got %b%b expected 10", gnt1, gnt0); end
        cyc(); reset_n = 1'b0; #1;
        checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL mid_inflight: got rvalid1=%b expected 1", rvalid1); end
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b%b expected 00", gnt1, gnt0); end
        cyc(); reset_n = 1'b1; #1;
        checks++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rvalid_clr: got %b%b expected 00", rvalid1, rvalid0); end
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got gnt1,gnt0=%b%b expected 01", gnt1, gnt0); end
        cyc(); req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            checks++;
            if (mem_we !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL idle_c%0d: got we=%b g=%b%b v=%b%b expected all 0", i, mem_we, gnt1, gnt0, rvalid1, rvalid0);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; addr0 = 10'h000; addr1 = 10'h000;
        wdata0 = 16'h0000; wdata1 = 16'h0000;
        test_reset();
        test_both_read();
        test_write_read();
        test_burst();
        test_round_robin();
        test_reset_midburst();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
